// File: rtl/pulse_train_gen.sv
// pulse_train_gen: on start, emits N pulses, each high for H cycles, with
// L-cycle low gaps between them, then strobes done_o. H=0 or L=0 run as 1.
// Optional feature macro: PULSE_TRAIN_GEN_CONTINUOUS_EN (N=0 gives an endless train).
module pulse_train_gen #(
    parameter int LEN_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] high_len_i,
    input  logic [LEN_W-1:0] low_len_i,
    input  logic [NUM_W-1:0] num_pulses_i,
    input  logic             abort_i,
    output logic             signal_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] high_q, high_d;
    logic [LEN_W-1:0] low_q, low_d;
    logic [LEN_W-1:0] phase_q, phase_d;
    logic [NUM_W-1:0] pulse_q, pulse_d;
    logic             signal_q, signal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
    logic             cont_q, cont_d;
`endif

    // A zero length would stall a phase forever, so it is promoted to 1.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

    // Registers: state, latched configuration, counters and the output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            high_q   <= '0;
            low_q    <= '0;
            phase_q  <= '0;
            pulse_q  <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
            cont_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            high_q   <= high_d;
            low_q    <= low_d;
            phase_q  <= phase_d;
            pulse_q  <= pulse_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
            cont_q   <= cont_d;
`endif
        end
    end

    // Next state; outputs are computed one cycle ahead so they leave as flops.
    always_comb begin
        state_d  = state_q;
        high_d   = high_q;
        low_d    = low_q;
        phase_d  = phase_q;
        pulse_d  = pulse_q;
        signal_d = signal_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
        cont_d   = cont_q;
`endif
        case (state_q)
            S_IDLE: begin
                signal_d = 1'b0;
                busy_d   = 1'b0;
                // Abort takes priority over a simultaneous start.
                if (start_i && !abort_i) begin
                    high_d  = eff_len(high_len_i);
                    low_d   = eff_len(low_len_i);
                    pulse_d = num_pulses_i;
                    phase_d = eff_len(high_len_i);
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
                    cont_d   = (num_pulses_i == '0);
                    state_d  = S_HIGH;
                    signal_d = 1'b1;
                    busy_d   = 1'b1;
`else
                    if (num_pulses_i == '0) begin
                        // Empty train: completes immediately, no waveform.
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_HIGH;
                        signal_d = 1'b1;
                        busy_d   = 1'b1;
                    end
`endif
                end
            end
            S_HIGH: begin
                if (abort_i) begin
                    state_d  = S_IDLE;
                    signal_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (phase_q > LEN_W'(1)) begin
                    phase_d = phase_q - LEN_W'(1);
                end else begin
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
                    if (!cont_q && pulse_q == NUM_W'(1)) begin
`else
                    if (pulse_q == NUM_W'(1)) begin
`endif
                        // Last pulse ends straight into IDLE: no trailing gap.
                        state_d  = S_IDLE;
                        signal_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        pulse_d  = '0;
                    end else begin
                        state_d  = S_LOW;
                        signal_d = 1'b0;
                        phase_d  = low_q;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
                        if (!cont_q) pulse_d = pulse_q - NUM_W'(1);
`else
                        pulse_d = pulse_q - NUM_W'(1);
`endif
                    end
                end
            end
            S_LOW: begin
                if (abort_i) begin
                    state_d  = S_IDLE;
                    signal_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (phase_q > LEN_W'(1)) begin
                    phase_d = phase_q - LEN_W'(1);
                end else begin
                    state_d  = S_HIGH;
                    signal_d = 1'b1;
                    phase_d  = high_q;
                end
            end
            default: begin
                state_d  = S_IDLE;
                signal_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign signal_o = signal_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: a queue-based waveform model checked every cycle,
// plus hand-computed waveforms for the directed scenarios.
module tb_pulse_train_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, abort_i;
  logic [7:0] high_len_i, low_len_i, num_pulses_i;
  logic       signal_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  pulse_train_gen #(.LEN_W(8), .NUM_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .high_len_i(high_len_i),
    .low_len_i(low_len_i), .num_pulses_i(num_pulses_i), .abort_i(abort_i),
    .signal_o(signal_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Model: queue of future {signal,busy,done} values, one entry per cycle.
  logic [2:0] mq[$];
  logic       m_sig = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic       m_cont = 1'b0;
  int         m_h = 1, m_l = 1;
  logic       cmp_en = 1'b0;

  always @(posedge clk) begin
    logic [2:0] nx;
    int n;
    if (rst) begin
      mq.delete(); m_cont = 1'b0;
    end else if (m_busy && abort_i) begin
      mq.delete(); m_cont = 1'b0;
    end else if (!m_busy && start_i && !abort_i) begin
      mq.delete();
      m_h = (high_len_i == 0) ? 1 : int'(high_len_i);
      m_l = (low_len_i == 0) ? 1 : int'(low_len_i);
      n = int'(num_pulses_i);
      if (n == 0) begin
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
        m_cont = 1'b1;
`else
        mq.push_back(3'b001);
`endif
      end else begin
        for (int p = 0; p < n; p++) begin
          for (int i = 0; i < m_h; i++) mq.push_back(3'b110);
          if (p < n - 1) for (int i = 0; i < m_l; i++) mq.push_back(3'b010);
        end
        mq.push_back(3'b001);
      end
    end
    if (mq.size() == 0 && m_cont) begin
      for (int i = 0; i < m_h; i++) mq.push_back(3'b110);
      for (int i = 0; i < m_l; i++) mq.push_back(3'b010);
    end
    nx = (mq.size() != 0) ? mq.pop_front() : 3'b000;
    {m_sig, m_busy, m_done} = nx;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if ({signal_o, busy_o, done_o} !== {m_sig, m_busy, m_done}) begin
        errors++;
        $display("FAIL model t=%0t: got sig/busy/done=%b%b%b expected %b%b%b",
                 $time, signal_o, busy_o, done_o, m_sig, m_busy, m_done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_start(input int h, input int l, input int n);
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b0;
    high_len_i = 8'(h); low_len_i = 8'(l); num_pulses_i = 8'(n);
  endtask

  // Samples k cycles (t+1..t+k, first sample in the MSB) and injects events:
  // kind 1 = start H=1 L=1 N=1, 2 = abort, 3 = reset, for one cycle after sample i.
  task automatic capture(input int k, input int e1_i, input int e1_k,
                         input int e2_i, input int e2_k,
                         output logic [31:0] s, output logic [31:0] b, output logic [31:0] d);
    s = '0; b = '0; d = '0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      s = {s[30:0], signal_o};
      b = {b[30:0], busy_o};
      d = {d[30:0], done_o};
      start_i = 1'b0; abort_i = 1'b0; rst = 1'b0;
      for (int e = 0; e < 2; e++) begin
        int ei, ek;
        ei = (e == 0) ? e1_i : e2_i;
        ek = (e == 0) ? e1_k : e2_k;
        if (i == ei) begin
          case (ek)
            1: begin start_i = 1'b1; high_len_i = 8'd1; low_len_i = 8'd1; num_pulses_i = 8'd1; end
            2: abort_i = 1'b1;
            3: rst = 1'b1;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start_i = 1'b0; abort_i = 1'b0; rst = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] s, b, d;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    high_len_i = '0; low_len_i = '0; num_pulses_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_outputs", {29'd0, signal_o, busy_o, done_o}, 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: H=3 L=2 N=1
    do_start(3, 2, 1);
    capture(5, -1, 0, -1, 0, s, b, d);
    chk("t1_signal", s, 32'b11100);
    chk("t1_busy", b, 32'b11100);
    chk("t1_done", d, 32'b00010);
    idle(2);

    // 2: H=2 L=3 N=3
    do_start(2, 3, 3);
    capture(15, -1, 0, -1, 0, s, b, d);
    chk("t2_signal", s, 32'b110001100011000);
    chk("t2_done", d, 32'b000000000000100);
    idle(2);

    // 3: H=0 L=0 N=2, then a new start in the done cycle
    do_start(0, 0, 2);
    capture(6, 3, 1, -1, 0, s, b, d);
    chk("t3_signal", s, 32'b101010);
    chk("t3_busy", b, 32'b111010);
    chk("t3_done", d, 32'b000101);
    idle(2);

    // 4: H=5 L=5 N=4, ignored start at t+3, abort in the 2nd HIGH (t+12)
    do_start(5, 5, 4);
    capture(16, 2, 1, 11, 2, s, b, d);
    chk("t4_signal", s, 32'b1111100000110000);
    chk("t4_busy", b, 32'b1111111111110000);
    chk("t4_done", d, 32'b0);
    idle(2);

    // 5: N=0
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
    do_start(1, 1, 0);
    capture(8, 5, 2, -1, 0, s, b, d);
    chk("t5_signal", s, 32'b10101000);
    chk("t5_busy", b, 32'b11111100);
    chk("t5_done", d, 32'b0);
`else
    do_start(4, 4, 0);
    capture(3, -1, 0, -1, 0, s, b, d);
    chk("t5_signal", s, 32'b000);
    chk("t5_busy", b, 32'b000);
    chk("t5_done", d, 32'b100);
`endif
    idle(2);

    // 6: reset during the first LOW of an N=4 train, then a clean train
    do_start(2, 3, 4);
    capture(8, 2, 3, -1, 0, s, b, d);
    chk("t6_signal", s, 32'b11000000);
    chk("t6_busy", b, 32'b11100000);
    chk("t6_done", d, 32'b0);
    do_start(3, 2, 1);
    capture(5, -1, 0, -1, 0, s, b, d);
    chk("t6_restart_signal", s, 32'b11100);
    chk("t6_restart_done", d, 32'b00010);
    idle(2);

    // Max high length, model-checked
    do_start(255, 1, 2);
    idle(520);

    // Randomized traffic, model-checked every cycle
    for (int it = 0; it < 3000; it++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 199);
      start_i = (r < 40);
      abort_i = (r >= 40 && r < 46) || (r >= 100 && r < 103 && start_i);
      rst = (r == 199);
      high_len_i = 8'($urandom_range(0, 4));
      low_len_i = 8'($urandom_range(0, 4));
      num_pulses_i = 8'($urandom_range(0, 4));
    end
    idle(4);
    rst = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
